noc_out_arbiter: RTL and testbench

Wormhole-aware round-robin arbiter for one router output port. It shares the port between up to `N_REQ` input ports (north, south, west, east, local) of the same router. Once a head flit wins, the port stays locked to that requester until its tail flit transfers, so packets never interleave. One instance sits per output port inside each router, between the input buffers and the output crossbar mux.

---
 rtl/noc_out_arbiter.sv | 146 ++++++++++++++
 tb/tb_noc_out_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter: wormhole-aware round-robin arbiter for one router output.
// A head flit wins the port, which then stays locked to that requester until
// its tail flit transfers, so packets never interleave on the link.
// Optional stall watchdog: define NOC_ARB_WDOG_EN to build it in; otherwise
// wdog_err_o is tied low.
module noc_out_arbiter #(
  parameter int N_REQ       = 5,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                     clk_noc,
  input  logic                     arst_noc,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         head_i,
  input  logic [N_REQ-1:0]         tail_i,
  input  logic                     ready_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_o,
  output logic                     valid_o,
  output logic                     locked_o,
  output logic                     wdog_err_o
);

  localparam int IDX_W = $clog2(N_REQ);

  // Elaboration-time guard on the supported parameter ranges.
  if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES < 2 || WDOG_CYCLES > 65535) begin : g_bad_cfg
    $error("noc_out_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] win_idx, sel;
  logic             win_found;
  logic             xfer;
  int               cand;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Round-robin search over head-flit requesters, starting at ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_i[cand] && head_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Grant outputs and next-state: locked grant ignores every other requester,
  // and ready_i only feeds the next-state path, never the grant.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    sel         = (state == LOCKED) ? owner : win_idx;

    if (state == LOCKED) begin
      if (req_i[owner]) begin
        grant_o[owner] = 1'b1;
        grant_idx_o    = owner;
      end
    end else if (win_found) begin
      grant_o[win_idx] = 1'b1;
      grant_idx_o      = win_idx;
    end

    valid_o  = |grant_o;
    locked_o = (state == LOCKED);
    xfer     = valid_o & ready_i;

    // ptr advances only when a packet completes; a head seen while locked is
    // treated as body data.
    if (xfer) begin
      case (state)
        IDLE: begin
          if (tail_i[sel]) begin
            ptr_nxt = wrap_inc(sel);
          end else begin
            state_nxt = LOCKED;
            owner_nxt = sel;
          end
        end
        LOCKED: begin
          if (tail_i[sel]) begin
            state_nxt = IDLE;
            ptr_nxt   = wrap_inc(sel);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Arbitration state register; reset drops any lock immediately.
  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

`ifdef NOC_ARB_WDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES);

  logic [15:0] wdog_cnt;
  logic        wdog_err;
  logic        stall;

  assign stall      = (valid_o & ~ready_i) | (locked_o & ~valid_o);
  assign wdog_err_o = wdog_err;

  // Stall counter: cleared by any transfer (which covers every return to
  // IDLE), saturates at the limit; the error flag is sticky until reset.
  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else if (xfer) begin
      wdog_cnt <= '0;
    end else if (stall && wdog_cnt != WDOG_LIM) begin
      wdog_cnt <= wdog_cnt + 16'd1;
      if (wdog_cnt + 16'd1 == WDOG_LIM) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Self-checking bench for noc_out_arbiter (N_REQ=5, WDOG_CYCLES=8): directed
// scenarios plus random traffic against a packet-level reference model.
module tb_noc_out_arbiter;
  localparam int N = 5;

  logic         clk_noc = 1'b0;
  logic         arst_noc = 1'b1;
  logic [N-1:0] req_i = '0, head_i = '0, tail_i = '0;
  logic         ready_i = 1'b0;
  logic [N-1:0] grant_o;
  logic [2:0]   grant_idx_o;
  logic         valid_o, locked_o, wdog_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: is a packet open, who owns it, where the search starts.
  bit           m_locked;
  int           m_owner, m_ptr, m_win;
  logic [N-1:0] exp_grant;
  logic [2:0]   exp_idx;
  logic [9:0]   exp_v, obs;

  assign obs = {grant_o, grant_idx_o, valid_o, locked_o};

  noc_out_arbiter #(.N_REQ(N), .WDOG_CYCLES(8)) dut (
    .clk_noc(clk_noc), .arst_noc(arst_noc),
    .req_i(req_i), .head_i(head_i), .tail_i(tail_i), .ready_i(ready_i),
    .grant_o(grant_o), .grant_idx_o(grant_idx_o), .valid_o(valid_o),
    .locked_o(locked_o), .wdog_err_o(wdog_err_o)
  );

  always #5 clk_noc = ~clk_noc;

  initial begin
    #2000000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1);
  end

  // Who should be granted: the open packet's owner if it is requesting,
  // else the first head requester walking round from the pointer.
  function automatic int model_pick(input logic [N-1:0] r, input logic [N-1:0] h);
    if (m_locked) return r[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (r[j] && h[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_win = -1;
  endtask

  // Drive one cycle of inputs mid-period and work out the expected outputs.
  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] h,
                       input logic [N-1:0] t, input logic rdy);
    @(negedge clk_noc);
    req_i = r; head_i = h; tail_i = t; ready_i = rdy;
    #1;
    m_win     = model_pick(r, h);
    exp_grant = '0;
    exp_idx   = '0;
    if (m_win >= 0) begin
      exp_grant[m_win] = 1'b1;
      exp_idx          = 3'(m_win);
    end
    exp_v = {exp_grant, exp_idx, (m_win >= 0), m_locked};
  endtask

  // Advance the model across the clock edge by the packet rules.
  task automatic tick();
    @(posedge clk_noc);
    if (m_win >= 0 && ready_i) begin
      if (tail_i[m_win]) begin
        m_locked = 0;
        m_ptr    = (m_win + 1) % N;
      end else if (!m_locked) begin
        m_locked = 1;
        m_owner  = m_win;
      end
    end
  endtask

  task automatic test_reset();
    arst_noc = 1'b1; req_i = '0; head_i = '0; tail_i = '0; ready_i = 1'b0;
    repeat (2) @(negedge clk_noc);
    #1;
    n_tests++;
    if ({obs, wdog_err_o} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state got %b want %b", {obs, wdog_err_o}, 11'b0);
    end
    model_reset();
    @(negedge clk_noc);
    arst_noc = 1'b0;
  endtask

  task automatic test_rr_fairness();
    int seq[6] = '{0, 2, 4, 0, 2, 4};
    for (int i = 0; i < 6; i++) begin
      apply(5'b10101, 5'b10101, 5'b10101, 1'b1);
      n_tests++;
      if (grant_idx_o !== 3'(seq[i]) || obs !== exp_v) begin
        n_fail++;
        $display("FAIL rr_fairness[%0d] got idx %0d obs %b want idx %0d obs %b",
                 i, grant_idx_o, obs, seq[i], exp_v);
      end
      tick();
    end
  endtask

  task automatic test_wormhole();
    // Cycle 4 offers heads on 0 and 3: only ptr=2 after the tail picks 3.
    logic [N-1:0] r[6] = '{5'b00010, 5'b01010, 5'b01010, 5'b01010, 5'b01001, 5'b00001};
    logic [N-1:0] h[6] = '{5'b00010, 5'b01000, 5'b01000, 5'b01000, 5'b01001, 5'b00001};
    logic [N-1:0] t[6] = '{5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b01001, 5'b00001};
    logic [N-1:0] g[6] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b01000, 5'b00001};
    logic         lk[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(r[i], h[i], t[i], 1'b1);
      n_tests++;
      if (grant_o !== g[i] || locked_o !== lk[i] || obs !== exp_v) begin
        n_fail++;
        $display("FAIL wormhole[%0d] got grant %b lock %b want grant %b lock %b",
                 i, grant_o, locked_o, g[i], lk[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply(5'b00100, 5'b00100, 5'b00000, 1'b1);
    n_tests++;
    if (grant_o !== 5'b00100 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL bp_head got %b want %b", grant_o, 5'b00100);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      apply(5'b00101, 5'b00001, 5'b00100, 1'b0);
      n_tests++;
      if (grant_o !== 5'b00100 || locked_o !== 1'b1 || obs !== exp_v) begin
        n_fail++;
        $display("FAIL bp_stall[%0d] got grant %b lock %b want grant 00100 lock 1",
                 i, grant_o, locked_o);
      end
      tick();
    end
    apply(5'b00101, 5'b00001, 5'b00100, 1'b1);
    tick();
    apply(5'b00001, 5'b00001, 5'b00001, 1'b1);
    n_tests++;
    if (grant_o !== 5'b00001 || locked_o !== 1'b0 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL bp_release got grant %b lock %b want grant 00001 lock 0",
               grant_o, locked_o);
    end
    tick();
  endtask

  task automatic test_owner_bubble();
    apply(5'b00001, 5'b00001, 5'b00000, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(5'b10000, 5'b10000, 5'b10000, 1'b1);
      n_tests++;
      if (grant_o !== 5'b00000 || locked_o !== 1'b1 || obs !== exp_v) begin
        n_fail++;
        $display("FAIL bubble[%0d] got grant %b lock %b want grant 00000 lock 1",
                 i, grant_o, locked_o);
      end
      tick();
    end
    apply(5'b10001, 5'b10000, 5'b10001, 1'b1);
    n_tests++;
    if (grant_o !== 5'b00001 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL bubble_tail got %b want %b", grant_o, 5'b00001);
    end
    tick();
    apply(5'b10000, 5'b10000, 5'b10000, 1'b1);
    n_tests++;
    if (grant_o !== 5'b10000 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL bubble_next got %b want %b", grant_o, 5'b10000);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    apply(5'b00010, 5'b00010, 5'b00010, 1'b1);  // moves ptr away from 0
    tick();
    apply(5'b01000, 5'b01000, 5'b00000, 1'b1);  // owner 3 locks
    tick();
    @(negedge clk_noc);
    req_i = 5'b01000; head_i = '0; tail_i = '0; ready_i = 1'b1;
    arst_noc = 1'b1;
    #1;
    n_tests++;
    if (locked_o !== 1'b0 || grant_o !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_mid got lock %b grant %b want lock 0 grant 00000",
               locked_o, grant_o);
    end
    model_reset();
    @(negedge clk_noc);
    arst_noc = 1'b0;
    apply(5'b11111, 5'b11111, 5'b11111, 1'b1);
    n_tests++;
    if (grant_idx_o !== 3'd0 || grant_o !== 5'b00001 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_restart got idx %0d grant %b want idx 0 grant 00001",
               grant_idx_o, grant_o);
    end
    tick();
  endtask

  task automatic test_watchdog();
    logic exp_err;
`ifdef NOC_ARB_WDOG_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      apply(5'b00001, 5'b00001, 5'b00001, 1'b0);
      n_tests++;
      if (wdog_err_o !== 1'b0 || obs !== exp_v) begin
        n_fail++;
        $display("FAIL wdog_before[%0d] got err %b want 0", i, wdog_err_o);
      end
      tick();
    end
    apply(5'b00001, 5'b00001, 5'b00001, 1'b1);
    n_tests++;
    if (wdog_err_o !== exp_err) begin
      n_fail++;
      $display("FAIL wdog_trip got %b want %b", wdog_err_o, exp_err);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(5'b00010, 5'b00010, 5'b00010, 1'b1);
      tick();
    end
    #1;
    n_tests++;
    if (wdog_err_o !== exp_err) begin
      n_fail++;
      $display("FAIL wdog_sticky got %b want %b", wdog_err_o, exp_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(5'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(3) != 0));
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d] got {grant,idx,valid,lock}=%b want %b", i, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_wormhole();
    test_backpressure();
    test_owner_bubble();
    test_reset_mid_packet();
    test_reset();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
